// File: rtl/adim_kontrol_if.sv
// Button/result bundle between the cursor controller and its surroundings.
// slave = the controller itself; master = whoever drives buttons and the checker result.
interface adim_kontrol_if;
    logic       sag_btn;
    logic       asagi_btn;
    logic       onay_btn;
    logic       tahmin_dogru;
    logic [1:0] sag_adim;
    logic [1:0] asagi_adim;
    logic       gecerli;
    logic       son_dogru;
    logic [3:0] skor;
    logic [3:0] deneme;
    logic       oyun_bitti;
    logic [1:0] durum;

    // Handshake: gecerli marks the single cycle in which sag_adim/asagi_adim are
    // frozen and tahmin_dogru is consumed; there is no back-pressure.
    modport slave (
        input  sag_btn, asagi_btn, onay_btn, tahmin_dogru,
        output sag_adim, asagi_adim, gecerli, son_dogru, skor, deneme, oyun_bitti, durum
    );

    modport master (
        output sag_btn, asagi_btn, onay_btn, tahmin_dogru,
        input  sag_adim, asagi_adim, gecerli, son_dogru, skor, deneme, oyun_bitti, durum
    );
endinterface

// File: rtl/adim_kontrol.sv
// Cursor/round controller for the 4x4 number-guess game.
// Optional macro ADIM_DEBOUNCE_EN inserts a counter debounce filter on each button.
module adim_kontrol #(
    parameter int MAX_DENEME      = 8,
    parameter bit SARMA           = 1'b1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    adim_kontrol_if.slave bus
);

    typedef enum logic [1:0] {
        HAREKET = 2'd0,
        KILIT   = 2'd1,
        SONUC   = 2'd2,
        BITTI   = 2'd3
    } durum_t;

    localparam logic [3:0] MAX_D = 4'(MAX_DENEME);

    if (MAX_DENEME < 1 || MAX_DENEME > 15 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_hata
        $error("adim_kontrol: parameter out of legal range");
    end

    // Bit order everywhere: [0]=right, [1]=down, [2]=confirm.
    logic [2:0] ham;
    logic [2:0] senk1, senk2, onceki, seviye, darbe;

    assign ham = {bus.onay_btn, bus.asagi_btn, bus.sag_btn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            senk1  <= '0;
            senk2  <= '0;
            onceki <= '0;
        end else begin
            senk1  <= ham;
            senk2  <= senk1;
            onceki <= seviye;
        end
    end

`ifdef ADIM_DEBOUNCE_EN
    localparam logic [7:0] DB_SON = 8'(DEBOUNCE_CYCLES - 1);

    logic [2:0] filtre;
    logic [7:0] sayac [3];

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filtre <= '0;
            for (int i = 0; i < 3; i++) sayac[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (senk2[i] != filtre[i]) begin
                    if (sayac[i] == DB_SON) begin
                        filtre[i] <= senk2[i];
                        sayac[i]  <= '0;
                    end else begin
                        sayac[i]  <= sayac[i] + 8'd1;
                    end
                end else begin
                    sayac[i] <= '0;
                end
            end
        end
    end

    assign seviye = filtre;
`else
    assign seviye = senk2;
`endif

    assign darbe = seviye & ~onceki;

    function automatic logic [1:0] adim_art(input logic [1:0] v);
        if (SARMA) return v + 2'd1;
        else       return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    durum_t     durum, durum_d;
    logic [1:0] sag_q, asagi_q, sag_d, asagi_d;
    logic       son_q, son_d;
    logic [3:0] skor_q, skor_d, deneme_q, deneme_d, deneme_art;
    logic       gecerli, oyun_bitti;

    assign deneme_art = deneme_q + 4'd1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) durum <= HAREKET;
        else        durum <= durum_d;
    end

    // Next-state logic.
    always_comb begin
        durum_d = durum;
        case (durum)
            HAREKET: if (darbe[2]) durum_d = KILIT;
            KILIT:   durum_d = (deneme_art == MAX_D) ? BITTI : SONUC;
            SONUC:   if (|darbe) durum_d = HAREKET;
            BITTI:   durum_d = BITTI;
            default: durum_d = HAREKET;
        endcase
    end

    // Output logic: flags plus next values of the coordinate/score registers.
    always_comb begin
        sag_d      = sag_q;
        asagi_d    = asagi_q;
        son_d      = son_q;
        skor_d     = skor_q;
        deneme_d   = deneme_q;
        gecerli    = (durum == KILIT);
        oyun_bitti = (durum == BITTI);
        case (durum)
            HAREKET: begin
                // A confirm in the same cycle discards any move.
                if (!darbe[2]) begin
                    if (darbe[0]) sag_d   = adim_art(sag_q);
                    if (darbe[1]) asagi_d = adim_art(asagi_q);
                end
            end
            KILIT: begin
                son_d    = bus.tahmin_dogru;
                skor_d   = skor_q + {3'b000, bus.tahmin_dogru};
                deneme_d = deneme_art;
            end
            SONUC: begin
                if (|darbe) begin
                    sag_d   = 2'd0;
                    asagi_d = 2'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sag_q    <= '0;
            asagi_q  <= '0;
            son_q    <= 1'b0;
            skor_q   <= '0;
            deneme_q <= '0;
        end else begin
            sag_q    <= sag_d;
            asagi_q  <= asagi_d;
            son_q    <= son_d;
            skor_q   <= skor_d;
            deneme_q <= deneme_d;
        end
    end

    assign bus.sag_adim   = sag_q;
    assign bus.asagi_adim = asagi_q;
    assign bus.gecerli    = gecerli;
    assign bus.son_dogru  = son_q;
    assign bus.skor       = skor_q;
    assign bus.deneme     = deneme_q;
    assign bus.oyun_bitti = oyun_bitti;
    assign bus.durum      = durum;

endmodule

// File: tb/tb_adim_kontrol.sv
// Bench for adim_kontrol: three variants (wrap, saturate, MAX_DENEME=2) share one
// button stimulus; a press-level reference model feeds an expected-result queue.
module tb_adim_kontrol;
    localparam int W = 17;
`ifdef ADIM_DEBOUNCE_EN
    localparam int EK = 16;
`else
    localparam int EK = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sag_b = 1'b0, asagi_b = 1'b0, onay_b = 1'b0;
    logic [1:0] hedef_sag = 2'd1, hedef_asagi = 2'd2;

    adim_kontrol_if bus_a ();
    adim_kontrol_if bus_b ();
    adim_kontrol_if bus_c ();

    assign bus_a.sag_btn = sag_b;  assign bus_a.asagi_btn = asagi_b;  assign bus_a.onay_btn = onay_b;
    assign bus_b.sag_btn = sag_b;  assign bus_b.asagi_btn = asagi_b;  assign bus_b.onay_btn = onay_b;
    assign bus_c.sag_btn = sag_b;  assign bus_c.asagi_btn = asagi_b;  assign bus_c.onay_btn = onay_b;
    // Downstream checker: correct when the cursor sits on the hidden target.
    assign bus_a.tahmin_dogru = (bus_a.sag_adim == hedef_sag) && (bus_a.asagi_adim == hedef_asagi);
    assign bus_b.tahmin_dogru = (bus_b.sag_adim == hedef_sag) && (bus_b.asagi_adim == hedef_asagi);
    assign bus_c.tahmin_dogru = (bus_c.sag_adim == hedef_sag) && (bus_c.asagi_adim == hedef_asagi);

    adim_kontrol #(.MAX_DENEME(8), .SARMA(1'b1), .DEBOUNCE_CYCLES(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    adim_kontrol #(.MAX_DENEME(8), .SARMA(1'b0), .DEBOUNCE_CYCLES(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    adim_kontrol #(.MAX_DENEME(2), .SARMA(1'b1), .DEBOUNCE_CYCLES(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] snap(input int d);
        case (d)
            0: return {bus_a.durum, bus_a.sag_adim, bus_a.asagi_adim, bus_a.gecerli, bus_a.son_dogru,
                       bus_a.skor, bus_a.deneme, bus_a.oyun_bitti};
            1: return {bus_b.durum, bus_b.sag_adim, bus_b.asagi_adim, bus_b.gecerli, bus_b.son_dogru,
                       bus_b.skor, bus_b.deneme, bus_b.oyun_bitti};
            default: return {bus_c.durum, bus_c.sag_adim, bus_c.asagi_adim, bus_c.gecerli, bus_c.son_dogru,
                       bus_c.skor, bus_c.deneme, bus_c.oyun_bitti};
        endcase
    endfunction

    function automatic logic gecerli_of(input int d);
        case (d)
            0: return bus_a.gecerli;
            1: return bus_b.gecerli;
            default: return bus_c.gecerli;
        endcase
    endfunction

    // Reference model, advanced once per complete button press.
    int         m_durum [3];
    logic [1:0] m_sag [3], m_asagi [3];
    logic       m_son [3];
    logic [3:0] m_skor [3], m_den [3];
    int         max_d [3] = '{8, 8, 2};
    bit         sarma [3] = '{1'b1, 1'b0, 1'b1};

    function automatic logic [1:0] m_art(input logic [1:0] v, input bit s);
        if (v == 2'd3) return s ? 2'd0 : 2'd3;
        return v + 2'd1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_durum[d] = 0; m_sag[d] = 0; m_asagi[d] = 0; m_son[d] = 0; m_skor[d] = 0; m_den[d] = 0;
        end
    endtask

    task automatic model_step(input logic [2:0] mask);
        for (int d = 0; d < 3; d++) begin
            case (m_durum[d])
                0: begin
                    if (mask[2]) begin
                        m_son[d]   = (m_sag[d] == hedef_sag) && (m_asagi[d] == hedef_asagi);
                        m_skor[d]  = m_skor[d] + {3'b000, m_son[d]};
                        m_den[d]   = m_den[d] + 4'd1;
                        m_durum[d] = (int'(m_den[d]) == max_d[d]) ? 3 : 2;
                    end else begin
                        if (mask[0]) m_sag[d]   = m_art(m_sag[d], sarma[d]);
                        if (mask[1]) m_asagi[d] = m_art(m_asagi[d], sarma[d]);
                    end
                end
                2: if (mask != 3'b000) begin m_sag[d] = 0; m_asagi[d] = 0; m_durum[d] = 0; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [W-1:0] model_vec(input int d);
        return {2'(m_durum[d]), m_sag[d], m_asagi[d], 1'b0, m_son[d], m_skor[d], m_den[d], (m_durum[d] == 3)};
    endfunction

    task automatic push_and_compare(input string tag);
        for (int d = 0; d < 3; d++) exp_q.push_back(model_vec(d));
        for (int d = 0; d < 3; d++) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check($sformatf("%s_dut%0d", tag, d), snap(d), e);
        end
    endtask

    // Drive a press of the buttons in mask, count gecerli cycles, then compare.
    task automatic press(input logic [2:0] mask, input int hold, input bit lat_chk, input string tag);
        int g [3];
        int g_exp [3];
        logic [1:0] s_pre, s_lat;
        s_pre = 2'd0; s_lat = 2'd0;
        for (int d = 0; d < 3; d++) begin
            g[d] = 0;
            g_exp[d] = (m_durum[d] == 0 && mask[2]) ? 1 : 0;
        end
        @(negedge clk);
        {onay_b, asagi_b, sag_b} = mask;
        for (int i = 0; i < hold + 2 * EK + 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) g[d] += int'(gecerli_of(d));
            if (i == 1 + EK) s_pre = bus_a.sag_adim;
            if (i == 2 + EK) s_lat = bus_a.sag_adim;
            if (i == hold + EK - 1) {onay_b, asagi_b, sag_b} = 3'b000;
        end
        for (int d = 0; d < 3; d++) check($sformatf("%s_gec%0d", tag, d), W'(g[d]), W'(g_exp[d]));
        if (lat_chk) begin
            check("lat_edge2", W'(s_pre), W'(0));
            check("lat_edge3", W'(s_lat), W'(1));
        end
        model_step(mask);
        push_and_compare(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g_cnt;
        logic [1:0] st_k;
        logic [3:0] xy_k;
        model_reset();
        repeat (3) @(negedge clk);
        push_and_compare("reset");
        rst_n = 1'b1;

        press(3'b001, 4, 1'b1, "r1");
        press(3'b001, 4, 1'b0, "r2");
        press(3'b010, 4, 1'b0, "d1");
        check("move_xy", W'({bus_a.sag_adim, bus_a.asagi_adim}), W'({2'd2, 2'd1}));

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) press(3'b001, 4, 1'b0, $sformatf("r5_%0d", k));
        check("wrap_a", W'(bus_a.sag_adim), W'(1));
        check("sat_b", W'(bus_b.sag_adim), W'(3));

        press(3'b010, 4, 1'b0, "d_a");
        press(3'b010, 4, 1'b0, "d_b");
        press(3'b100, 4, 1'b0, "onay1");
        press(3'b010, 4, 1'b0, "sonuc_d");
        check("sonuc_xy", W'({bus_a.sag_adim, bus_a.asagi_adim}), W'(0));
        press(3'b101, 4, 1'b0, "onay_sag");
        check("bitti_c", W'(bus_c.oyun_bitti), W'(1));
        press(3'b001, 4, 1'b0, "r_after");
        press(3'b100, 4, 1'b0, "onay2");
        press(3'b010, 6, 1'b0, "d_back");

        // Asynchronous reset while dut_a is in KILIT, then release with confirm held.
        @(negedge clk);
        onay_b = 1'b1;
        for (int i = 0; i <= 2 + EK; i++) begin @(posedge clk); @(negedge clk); end
        check("kilit_before_rst", W'(bus_a.durum), W'(1));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) check($sformatf("rst_async_dut%0d", d), snap(d), model_vec(d));
        @(negedge clk);
        rst_n = 1'b1;
        g_cnt = 0; st_k = 2'd0; xy_k = 4'hf;
        for (int i = 0; i < 12 + 2 * EK; i++) begin
            @(posedge clk);
            @(negedge clk);
            g_cnt += int'(bus_a.gecerli);
            if (i == 2 + EK) begin st_k = bus_a.durum; xy_k = {bus_a.sag_adim, bus_a.asagi_adim}; end
            if (i == 10 + EK) onay_b = 1'b0;
        end
        check("held_rst_gec", W'(g_cnt), W'(1));
        check("held_rst_kilit", W'(st_k), W'(1));
        check("held_rst_xy", W'(xy_k), W'(0));
        model_step(3'b100);
        push_and_compare("held_rst");

        press(3'b010, 4, 1'b0, "d_ret");
        press(3'b001, 12, 1'b0, "long_r");
        check("long_r_once", W'(bus_a.sag_adim), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
